// File: rtl/hex_word_display.sv
// hex_word_display: fetches the 32-bit word at `addr` from the memory read
// port and scans it as eight hex digits on a multiplexed active-low display.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   addr[7:0]       word address (bit 7: 0 instruction, 1 data memory)
//   mem_rd_en       one-cycle read strobe
//   mem_addr[7:0]   read address, stable from strobe to capture
//   mem_rdata[31:0] read data, valid the cycle after the strobe is sampled
//   an[7:0]         digit enables, active-low, digit 0 rightmost
//   seg[6:0]        segments {g,f,e,d,c,b,a}, active-low
//   dp              decimal point, active-low (data-memory marker on digit 7)
//   word_valid      high once a word has been captured since reset
module hex_word_display #(
   parameter int DIGIT_PERIOD = 100_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  addr,
   output logic        mem_rd_en,
   output logic [7:0]  mem_addr,
   input  logic [31:0] mem_rdata,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        word_valid
);

   localparam int CW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_READ    = 2'd1,
      S_CAPTURE = 2'd2
   } state_t;

   state_t        r_state, w_state_nxt;
   logic          r_rd_en, w_rd_en_nxt;
   logic [7:0]    r_mem_addr, w_mem_addr_nxt;
   logic [31:0]   r_word, w_word_nxt;
   logic          r_valid, w_valid_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          w_cnt_wrap;
   logic [2:0]    r_dig, w_dig_nxt;
   logic [3:0]    w_nib;
   logic [6:0]    w_glyph;
   logic [7:0]    r_an, w_an_nxt;
   logic [6:0]    r_seg, w_seg_nxt;
   logic          r_dp, w_dp_nxt;

   // Fetch FSM next-state
   always_comb begin
      w_state_nxt    = r_state;
      w_rd_en_nxt    = 1'b0;
      w_mem_addr_nxt = r_mem_addr;
      w_word_nxt     = r_word;
      w_valid_nxt    = r_valid;
      case (r_state)
         S_IDLE: begin
            if ((addr != r_mem_addr) || !r_valid) begin
               w_mem_addr_nxt = addr;
               w_rd_en_nxt    = 1'b1;
               w_state_nxt    = S_READ;
            end
         end
         S_READ: begin
            w_state_nxt = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_word_nxt  = mem_rdata;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Scan counters
   assign w_cnt_wrap = (r_cnt == CW'(DIGIT_PERIOD - 1));
   assign w_cnt_nxt  = w_cnt_wrap ? '0 : r_cnt + CW'(1);
   assign w_dig_nxt  = w_cnt_wrap ? r_dig + 3'd1 : r_dig;

   // Pins are built from next-state values so the glyph, enable and
   // captured word all land on the same edge with no slot lag.
   assign w_nib = w_word_nxt[{w_dig_nxt, 2'b00} +: 4];

   always_comb begin
      w_glyph = 7'h7F;
      unique case (w_nib)
         4'h0: w_glyph = 7'b1000000;
         4'h1: w_glyph = 7'b1111001;
         4'h2: w_glyph = 7'b0100100;
         4'h3: w_glyph = 7'b0110000;
         4'h4: w_glyph = 7'b0011001;
         4'h5: w_glyph = 7'b0010010;
         4'h6: w_glyph = 7'b0000010;
         4'h7: w_glyph = 7'b1111000;
         4'h8: w_glyph = 7'b0000000;
         4'h9: w_glyph = 7'b0010000;
         4'hA: w_glyph = 7'b0001000;
         4'hB: w_glyph = 7'b0000011;
         4'hC: w_glyph = 7'b1000110;
         4'hD: w_glyph = 7'b0100001;
         4'hE: w_glyph = 7'b0000110;
         4'hF: w_glyph = 7'b0001110;
      endcase
   end

   // Count 0 of each slot blanks all digits to avoid ghosting.
   always_comb begin
      w_an_nxt  = 8'hFF;
      w_seg_nxt = 7'h7F;
      w_dp_nxt  = 1'b1;
      if (w_valid_nxt) begin
         w_seg_nxt = w_glyph;
         if (w_cnt_nxt != '0) begin
            w_an_nxt = ~(8'd1 << w_dig_nxt);
            if ((w_dig_nxt == 3'd7) && w_mem_addr_nxt[7]) begin
               w_dp_nxt = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_rd_en    <= 1'b0;
         r_mem_addr <= 8'h00;
         r_word     <= 32'h0;
         r_valid    <= 1'b0;
         r_cnt      <= '0;
         r_dig      <= 3'd0;
         r_an       <= 8'hFF;
         r_seg      <= 7'h7F;
         r_dp       <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_rd_en    <= w_rd_en_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_word     <= w_word_nxt;
         r_valid    <= w_valid_nxt;
         r_cnt      <= w_cnt_nxt;
         r_dig      <= w_dig_nxt;
         r_an       <= w_an_nxt;
         r_seg      <= w_seg_nxt;
         r_dp       <= w_dp_nxt;
      end
   end

   assign mem_rd_en  = r_rd_en;
   assign mem_addr   = r_mem_addr;
   assign word_valid = r_valid;
   assign an         = r_an;
   assign seg        = r_seg;
   assign dp         = r_dp;

endmodule

// File: tb/tb_hex_word_display.sv
// tb_hex_word_display: bench for hex_word_display with a small memory model
// and a queue of expected words captured by the display.
module tb_hex_word_display;

   logic        clk;
   logic        rst_n;
   logic [7:0]  addr;
   logic        mem_rd_en;
   logic [7:0]  mem_addr;
   logic [31:0] mem_rdata;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        word_valid;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [256];

   logic [31:0] exp_q [$];
   logic        pend;
   logic        m_valid;
   logic [31:0] m_word;

   int   n_pulses = 0;
   int   long_pulse = 0;
   logic rd_prev = 1'b0;

   hex_word_display #(.DIGIT_PERIOD(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .addr       (addr),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .word_valid (word_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous read memory
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   // Scoreboard: push on sampled strobe, pop on the capture edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         pend    = 1'b0;
         m_valid = 1'b0;
         m_word  = 32'h0;
      end else begin
         if (pend) begin
            if (exp_q.size() > 0) m_word = exp_q.pop_front();
            m_valid = 1'b1;
            pend    = 1'b0;
         end
         if (mem_rd_en) begin
            exp_q.push_back(mem[mem_addr]);
            pend = 1'b1;
         end
      end
   end

   // Strobe pulse monitor
   always @(posedge clk) begin
      if (mem_rd_en) begin
         if (rd_prev) long_pulse++;
         else n_pulses++;
      end
      rd_prev = mem_rd_en;
   end

   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] g;
      case (n)
         4'h0: g = 7'b1000000;
         4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;
         4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;
         4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;
         4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;
         4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;
         4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   task automatic wait_neg(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic test_reset;
      int  p0;
      bit  seen0;
      bit  seen7;
      for (int i = 0; i < 256; i++) begin
         mem[i] = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3};
      end
      mem[8'h00] = 32'h12345678;
      rst_n = 1'b0;
      addr  = 8'h00;
      wait_neg(2);
      checks++;
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 ||
          word_valid !== 1'b0 || mem_rd_en !== 1'b0 ||
          mem_addr !== 8'h00) begin
         errors++;
         $display("FAIL reset_values: an=%h seg=%h dp=%b wv=%b rd=%b ma=%h required FF 7F 1 0 0 00",
                  an, seg, dp, word_valid, mem_rd_en, mem_addr);
      end
      p0 = n_pulses;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 8'h00 || word_valid !== 1'b0) begin
         errors++;
         $display("FAIL first_strobe: rd=%b ma=%h wv=%b required 1 00 0",
                  mem_rd_en, mem_addr, word_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (mem_rd_en !== 1'b0 || word_valid !== 1'b0) begin
         errors++;
         $display("FAIL edge2: rd=%b wv=%b required 0 0", mem_rd_en, word_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (word_valid !== 1'b1 || an !== 8'hFE || seg !== 7'b0000000) begin
         errors++;
         $display("FAIL edge3_capture: wv=%b an=%h seg=%b required 1 FE 0000000",
                  word_valid, an, seg);
      end
      seen0 = 0;
      seen7 = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (an == 8'hFE) begin
            seen0 = 1;
            checks++;
            if (seg !== 7'b0000000) begin
               errors++;
               $display("FAIL digit0_glyph: seg=%b required 0000000", seg);
            end
         end
         if (an == 8'h7F) begin
            seen7 = 1;
            checks++;
            if (seg !== 7'b1111001) begin
               errors++;
               $display("FAIL digit7_glyph: seg=%b required 1111001", seg);
            end
         end
      end
      checks++;
      if (!seen0 || !seen7 || n_pulses - p0 != 1) begin
         errors++;
         $display("FAIL reset_fetch: seen0=%b seen7=%b pulses=%0d required 1 1 1",
                  seen0, seen7, n_pulses - p0);
      end
   endtask

   task automatic test_scan;
      logic [7:0] prev;
      logic [7:0] exp;
      bit found;
      int d;
      found = 0;
      prev = an;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (prev == 8'h7F && an == 8'hFF) found = 1;
         prev = an;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL scan_sync: no 7F->FF transition seen within 80 cycles");
      end else begin
         for (int k = 0; k < 64; k++) begin
            if (k > 0) @(negedge clk);
            d = (k / 4) % 8;
            exp = (k % 4 == 0) ? 8'hFF : ~(8'h01 << d);
            checks++;
            if (an !== exp) begin
               errors++;
               $display("FAIL scan_an: k=%0d an=%h required %h", k, an, exp);
            end
            if (k % 4 != 0) begin
               checks++;
               if (seg !== glyph(m_word[4*d +: 4]) || dp !== 1'b1) begin
                  errors++;
                  $display("FAIL scan_seg: digit=%0d seg=%b dp=%b required %b 1",
                           d, seg, dp, glyph(m_word[4*d +: 4]));
               end
            end
         end
      end
   endtask

   task automatic test_data_mem;
      logic [7:0] exp_dp;
      bit seen7;
      mem[8'h85] = 32'hAAAAAAAF;
      addr = 8'h05;
      wait_neg(8);
      addr = 8'h85;
      @(posedge clk); #1;
      checks++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 8'h85) begin
         errors++;
         $display("FAIL refetch_strobe: rd=%b ma=%h required 1 85", mem_rd_en, mem_addr);
      end
      wait_neg(4);
      checks++;
      if (word_valid !== 1'b1 || m_word !== 32'hAAAAAAAF) begin
         errors++;
         $display("FAIL refetch_word: wv=%b model=%h required 1 AAAAAAAF",
                  word_valid, m_word);
      end
      seen7 = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         exp_dp = (an == 8'h7F) ? 8'd0 : 8'd1;
         if (an == 8'h7F) seen7 = 1;
         checks++;
         if (dp !== exp_dp[0]) begin
            errors++;
            $display("FAIL data_dp: an=%h dp=%b required %b", an, dp, exp_dp[0]);
         end
         if (an != 8'hFF) begin
            checks++;
            if ((an == 8'hFE && seg !== 7'b0001110) ||
                (an != 8'hFE && seg !== 7'b0001000)) begin
               errors++;
               $display("FAIL data_seg: an=%h seg=%b required %b", an, seg,
                        (an == 8'hFE) ? 7'b0001110 : 7'b0001000);
            end
         end
      end
      checks++;
      if (!seen7) begin
         errors++;
         $display("FAIL data_digit7: an=7F never seen");
      end
   endtask

   task automatic test_back_to_back;
      int p0;
      int l0;
      int d;
      mem[8'h12] = 32'h9E0CDB47;
      addr = 8'h20;
      wait_neg(8);
      p0 = n_pulses;
      l0 = long_pulse;
      addr = 8'h10;
      @(negedge clk);
      addr = 8'h11;
      @(negedge clk);
      addr = 8'h12;
      wait_neg(12);
      checks++;
      if (n_pulses - p0 < 1 || n_pulses - p0 > 2 || long_pulse != l0) begin
         errors++;
         $display("FAIL b2b_pulses: fetches=%0d long=%0d required 1..2 0",
                  n_pulses - p0, long_pulse - l0);
      end
      checks++;
      if (mem_addr !== 8'h12 || m_word !== 32'h9E0CDB47 || word_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_final: ma=%h model=%h wv=%b required 12 9E0CDB47 1",
                  mem_addr, m_word, word_valid);
      end
      for (int k = 0; k < 36; k++) begin
         @(negedge clk);
         if (an != 8'hFF) begin
            d = 0;
            for (int j = 0; j < 8; j++) if (an[j] == 1'b0) d = j;
            checks++;
            if (seg !== glyph(mem[8'h12][4*d +: 4])) begin
               errors++;
               $display("FAIL b2b_seg: digit=%0d seg=%b required %b",
                        d, seg, glyph(mem[8'h12][4*d +: 4]));
            end
         end
      end
   endtask

   task automatic test_reset_mid_read;
      int p0;
      addr = 8'h30;
      wait_neg(8);
      addr = 8'h31;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (an !== 8'hFF || seg !== 7'h7F || word_valid !== 1'b0 ||
          mem_rd_en !== 1'b0 || mem_addr !== 8'h00) begin
         errors++;
         $display("FAIL mid_read_reset: an=%h seg=%h wv=%b rd=%b ma=%h required FF 7F 0 0 00",
                  an, seg, word_valid, mem_rd_en, mem_addr);
      end
      @(negedge clk);
      p0 = n_pulses;
      rst_n = 1'b1;
      wait_neg(4);
      checks++;
      if (n_pulses - p0 != 1 || mem_addr !== 8'h31 || word_valid !== 1'b1 ||
          m_word !== mem[8'h31]) begin
         errors++;
         $display("FAIL post_reset_fetch: fetches=%0d ma=%h wv=%b model=%h required 1 31 1 %h",
                  n_pulses - p0, mem_addr, word_valid, m_word, mem[8'h31]);
      end
   endtask

   task automatic test_hold;
      int p0;
      wait_neg(4);
      p0 = n_pulses;
      wait_neg(1000);
      checks++;
      if (n_pulses != p0 || word_valid !== 1'b1) begin
         errors++;
         $display("FAIL hold_no_refetch: extra=%0d wv=%b required 0 1",
                  n_pulses - p0, word_valid);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_data_mem();
      test_back_to_back();
      test_reset_mid_read();
      test_hold();
      checks++;
      if (long_pulse != 0) begin
         errors++;
         $display("FAIL strobe_width: long pulses=%0d required 0", long_pulse);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
